conv_window_gen: RTL
====================

# conv_window_gen

- Streaming 3x3 window generator for the convolution datapath.
- Accepts one 16-bit pixel per cycle in raster order.
- Buffers the two previous image rows and presents all nine taps of each valid 3x3 neighbourhood in parallel.
- Sits directly upstream of the 9-lane multiplier layer: drives its nine pixel operands, with a valid strobe.

## Interface

- DATA_W, 16, pixel width (matches multiplier operand width)
- IMG_W, 8, pixels per row (≥3)
- IMG_H, 8, rows per frame (≥3)
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- pix_in  input  DATA_W  incoming pixel
- pix_valid  input  1  pix_in accepted this cycle when high; no backpressure
- win1..win9  output  DATA_W each  window taps, row-major: win1 top-left … win3 top-right, win4..win6 middle row, win9 bottom-right (newest pixel)
- win_valid  output  1  one-cycle strobe: win1..win9 form a complete window
- frame_done  output  1  one-cycle strobe after the last pixel of a frame is accepted

## Operation

- Counters: col (0..IMG_W-1), row (0..IMG_H-1), both advanced only on accepted pixels.
  - col wraps to 0 at IMG_W-1, incrementing row.
  - row wraps to 0 after (IMG_H-1, IMG_W-1), starting a new frame immediately.
- Two line buffers, each IMG_W deep FIFO shift chains:
  - lb0 holds row r-1; lb1 holds row r-2.
  - On accept: lb0_out (pixel at r-1,c) is pushed into lb1; pix_in is pushed into lb0.
  - The outgoing lb1_out (pixel at r-2,c) is used for the window.
- Window: 3x3 register array.
  - On accept, columns shift left.
  - New right column = {lb1_out, lb0_out, pix_in} into {win3, win6, win9}.
- Valid-only convolution, no padding.
  - win_valid asserts for an accept at (row≥2, col≥2).
  - (IMG_H-2)*(IMG_W-2) windows per frame.
- Windows at col 0/1 hold stale columns from the previous row. They are never flagged valid and their contents are don't-care.
- frame_done asserts for the accept at (IMG_H-1, IMG_W-1). In that cycle win_valid also asserts.
- No pix_valid: counters, line buffers and window hold. win_valid and frame_done are 0 next cycle.

## Timing

- Reset values: win1..win9 = 0, win_valid = 0, frame_done = 0, row = col = 0.
- Line buffer contents need not reset; rows 0/1 never produce valid windows.
- Latency: pixel accepted at edge t → window including it and win_valid visible after edge t (one register stage).
- win_valid and frame_done are registered; they are high for exactly one cycle per qualifying accept.
- Full throughput: pix_valid held high yields back-to-back windows along a row.
- Within a row, the gap between valid strobes equals the input gap.
- Each row has a 2-accept invalid gap at col 0/1.
- Reset mid-frame: the next accepted pixel is treated as (0,0) of a new frame.
  - No valid window until two full rows plus 3 pixels are re-accepted.
- rst has priority over pix_valid in the same cycle.

## Structure

- Shared header conv_defs.vh: DATA_W, default IMG_W/IMG_H.
  - The multiplier layer and adder stage include the same header so widths agree.
- One sub-module: conv_line_buffer (parameters DATA_W, DEPTH).
  - Ports: clk, en, din, dout.
  - Instantiated twice (lb0, lb1).
  - dout is the entry written DEPTH accepts earlier.
- Top holds the counters, the window registers and the strobes.

## Test plan

- IMG_W=IMG_H=4, pixels 1..16, pix_valid constant high:
  - exactly 4 win_valid strobes, following accepts of 11, 12, 15, 16.
  - First window = 1,2,3,5,6,7,9,10,11.
  - Last window = 6,7,8,10,11,12,14,15,16.
- Same frame with pix_valid toggling 1-0 (and random gaps):
  - identical 4 windows in identical order.
  - win_valid never high in a cycle following pix_valid=0.
- Two back-to-back frames (1..16 then 101..116):
  - frame_done pulses once after pixel 16 and once after pixel 116.
  - Second frame's first window = 101,102,103,105,106,107,109,110,111; no window mixes frames.
- Reset after pixel 7 of a frame, then pixels 1..16:
  - all outputs 0 the cycle after rst.
  - Subsequent output identical to the first scenario.
- IMG_W=8, IMG_H=3, ramp 0..23:
  - 6 windows; first = 0,1,2,8,9,10,16,17,18.
  - frame_done coincides with the last win_valid.
- rst and pix_valid high in the same cycle: pixel discarded; the counters remain 0.

Source files
------------

// File: rtl/conv_window_gen_pkg.sv
// conv_window_gen_pkg: shared pixel width and default frame geometry for the convolution datapath
package conv_window_gen_pkg;
    localparam int DATA_W    = 16;
    localparam int IMG_W_DEF = 8;
    localparam int IMG_H_DEF = 8;
    localparam int TAPS      = 9;
    typedef logic [DATA_W-1:0] pix_t;
endpackage

// File: rtl/conv_window_gen_if.sv
// conv_window_gen_if: pixel stream in, nine window taps plus strobes out
interface conv_window_gen_if;
    import conv_window_gen_pkg::*;
    pix_t pix_in;
    logic pix_valid;
    pix_t win1, win2, win3, win4, win5, win6, win7, win8, win9;
    logic win_valid;
    logic frame_done;
    modport master (
        output pix_in, pix_valid,
        input  win1, win2, win3, win4, win5, win6, win7, win8, win9, win_valid, frame_done
    );
    modport slave (
        input  pix_in, pix_valid,
        output win1, win2, win3, win4, win5, win6, win7, win8, win9, win_valid, frame_done
    );
endinterface

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: DEPTH-deep shift chain; dout is the entry written DEPTH enables earlier
module conv_line_buffer #(
    parameter int DATA_W = conv_window_gen_pkg::DATA_W,
    parameter int DEPTH  = conv_window_gen_pkg::IMG_W_DEF
) (
    input  logic              clk,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    logic [DATA_W-1:0] sr [DEPTH];
    always_ff @(posedge clk) begin
        if (en) begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end
    assign dout = sr[DEPTH-1];
endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming 3x3 window generator feeding the 9-lane multiplier layer
module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input logic clk,
    input logic rst,
    conv_window_gen_if.slave s
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          acc, col_last, row_last;
    pix_t          lb0_out, lb1_out;
    pix_t          w [TAPS];
    logic          win_valid, frame_done;
    assign acc      = s.pix_valid && !rst;
    assign col_last = col == CW'(IMG_W - 1);
    assign row_last = row == RW'(IMG_H - 1);
    // lb0 delays by one row (r-1), lb1 chains off it for r-2
    conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) lb0 (
        .clk(clk), .en(acc), .din(s.pix_in), .dout(lb0_out)
    );
    conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) lb1 (
        .clk(clk), .en(acc), .din(lb0_out), .dout(lb1_out)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < TAPS; i++) w[i] <= '0;
        end else begin
            win_valid  <= s.pix_valid && row >= RW'(2) && col >= CW'(2);
            frame_done <= s.pix_valid && row_last && col_last;
            if (s.pix_valid) begin
                col <= col_last ? '0 : col + CW'(1);
                if (col_last) row <= row_last ? '0 : row + RW'(1);
                for (int i = 0; i < 3; i++) begin
                    w[3*i]   <= w[3*i+1];
                    w[3*i+1] <= w[3*i+2];
                end
                w[2] <= lb1_out;
                w[5] <= lb0_out;
                w[8] <= s.pix_in;
            end
        end
    end
    assign s.win1       = w[0];
    assign s.win2       = w[1];
    assign s.win3       = w[2];
    assign s.win4       = w[3];
    assign s.win5       = w[4];
    assign s.win6       = w[5];
    assign s.win7       = w[6];
    assign s.win8       = w[7];
    assign s.win9       = w[8];
    assign s.win_valid  = win_valid;
    assign s.frame_done = frame_done;
endmodule
